// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if
// Bundles the two requester streams (x, y), the registered muxed output
// stream (o) and the status signals (s, busy) shared by mux_arbiter and
// whatever sits around it.
//
// Signals:
//   x, x_valid, x_ready   requester X data and handshake
//   y, y_valid, y_ready   requester Y data and handshake
//   o, o_valid, o_ready   registered muxed word and downstream handshake
//   s                     mux select, 0 = X, 1 = Y
//   busy                  arbiter is in a grant state
//
// Modports:
//   slave   the arbiter itself
//   master  the requesters plus the downstream consumer
interface mux_arbiter_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic             x_ready;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic             o_ready;
  logic             s;
  logic             busy;

  modport slave (
    input  x, x_valid, y, y_valid, o_ready,
    output x_ready, y_ready, o, o_valid, s, busy
  );

  modport master (
    output x, x_valid, y, y_valid, o_ready,
    input  x_ready, y_ready, o, o_valid, s, busy
  );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter
// Round-robin owner of a shared 2-to-1 data mux. One requester at a time is
// granted; its words are registered into a single output stage with a
// valid/ready handshake. A burst limit hands the mux to the other side after
// MAX_BURST accepted words whenever that side is waiting.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rst_n  synchronous, active-low reset
//   bus    mux_arbiter_if.slave (x/y request streams, o output stream, s, busy)
//
// Parameters:
//   WIDTH      data width of x, y and o
//   MAX_BURST  consecutive transfers allowed per grant under contention (1..15)
module mux_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_X,
    GRANT_Y
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             last_d;
  logic [3:0]       count_q;
  logic [3:0]       count_d;
  logic [3:0]       count_inc;
  logic [WIDTH-1:0] o_q;
  logic             o_valid_q;
  logic             load_en;
  logic             x_xfer;
  logic             y_xfer;
  logic [WIDTH-1:0] sel_data;

  // The output stage can take a new word when it is empty or its current
  // word is leaving this cycle; ready is only offered to the granted side.
  assign load_en     = !o_valid_q || bus.o_ready;
  assign bus.x_ready = (state_q == GRANT_X) && load_en;
  assign bus.y_ready = (state_q == GRANT_Y) && load_en;
  assign x_xfer      = bus.x_valid && bus.x_ready;
  assign y_xfer      = bus.y_valid && bus.y_ready;
  assign count_inc   = count_q + 4'd1;

  assign bus.s    = (state_q == GRANT_Y);
  assign bus.busy = (state_q != IDLE);
  assign sel_data = bus.s ? bus.y : bus.x;

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;

  // Next-state logic. last_q is 0 after an X grant and 1 after a Y grant, so
  // a tie in IDLE goes to the side that was not served most recently. Any
  // entry into a grant restarts the burst count. Reaching the burst limit
  // hands over only if the other side is actually waiting; otherwise the
  // current owner keeps the mux with a fresh count.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.x_valid && (!bus.y_valid || last_q)) begin
          state_d = GRANT_X;
          last_d  = 1'b0;
          count_d = 4'd0;
        end else if (bus.y_valid) begin
          state_d = GRANT_Y;
          last_d  = 1'b1;
          count_d = 4'd0;
        end
      end
      GRANT_X: begin
        if (!bus.x_valid) begin
          if (bus.y_valid) begin
            state_d = GRANT_Y;
            last_d  = 1'b1;
            count_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (x_xfer) begin
          if (count_inc == BURST_LIMIT) begin
            count_d = 4'd0;
            if (bus.y_valid) begin
              state_d = GRANT_Y;
              last_d  = 1'b1;
            end
          end else begin
            count_d = count_inc;
          end
        end
      end
      GRANT_Y: begin
        if (!bus.y_valid) begin
          if (bus.x_valid) begin
            state_d = GRANT_X;
            last_d  = 1'b0;
            count_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (y_xfer) begin
          if (count_inc == BURST_LIMIT) begin
            count_d = 4'd0;
            if (bus.x_valid) begin
              state_d = GRANT_X;
              last_d  = 1'b0;
            end
          end else begin
            count_d = count_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset leaves LAST pointing at Y so X wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Output stage. A transfer always overwrites o, even when the previous
  // word is being taken on the same edge; without a transfer a taken word
  // simply clears o_valid and o keeps its old contents. Reset discards
  // whatever was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else if (x_xfer || y_xfer) begin
      o_q       <= sel_data;
      o_valid_q <= 1'b1;
    end else if (o_valid_q && bus.o_ready) begin
      o_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin controller that shares one 2-to-1 data mux between two requesters (X and Y). It tracks which requester owns the mux, drives the mux select, and registers the selected word into a single output stage with a valid/ready handshake. A burst limit keeps one requester from starving the other. It sits between the two source datapaths and the downstream consumer of the muxed word.

## Interface
- WIDTH, 2, data width of X, Y and O
- MAX_BURST, 4, maximum consecutive accepted transfers per grant while the other side is waiting (legal range 1..15)

- CLK  input  1  single clock, all state updates on rising edge
- RST_N  input  1  reset, synchronous and active-low
- X  input  WIDTH  requester X data
- X_VALID  input  1  requester X has a word
- X_READY  output  1  X word accepted this cycle when X_VALID is also high
- Y  input  WIDTH  requester Y data
- Y_VALID  input  1  requester Y has a word
- Y_READY  output  1  Y word accepted this cycle when Y_VALID is also high
- O  output  WIDTH  registered muxed word
- O_VALID  output  1  O holds a word not yet taken downstream
- O_READY  input  1  downstream takes O this cycle when O_VALID is high
- S  output  1  mux select: 0 = X, 1 = Y
- BUSY  output  1  high in any grant state

## Operation
- FSM states: IDLE, GRANT_X, GRANT_Y. LAST flag records the last granted side.
- load_en = !O_VALID || O_READY. This is the output stage's ability to take a word.
- X_READY = (state == GRANT_X) && load_en. Y_READY = (state == GRANT_Y) && load_en. Both are combinational and never high together.
- A transfer occurs on any edge where VALID && READY. On that edge:
  - O is loaded with the granted data.
  - O_VALID is set.
  - burst count increments.
- If O_VALID && O_READY and no transfer occurs, O_VALID clears and O holds its value.
- IDLE transitions:
  - Both VALID high: grant the side opposite LAST.
  - Only one VALID high: grant that side.
  - Neither: stay in IDLE.
  - Entering a grant clears the count and sets LAST to the granted side.
- GRANT_X, evaluated each edge (GRANT_Y is symmetric):
  - X_VALID low: go to GRANT_Y if Y_VALID, else IDLE. Withdrawing a request is legal and ends the burst.
  - Transfer makes count reach MAX_BURST and Y_VALID is high: go to GRANT_Y with count 0.
  - Transfer makes count reach MAX_BURST and Y_VALID is low: stay, count resets to 0.
  - Otherwise: stay.
- S = 1 only in GRANT_Y; 0 in IDLE and GRANT_X.
- BUSY = (state != IDLE).
- Requesters must hold data stable while VALID is high and READY is low.

## Timing
- Reset values (RST_N low at an edge):
  - state IDLE, LAST = Y (so X wins the first tie)
  - count 0, O = 0, O_VALID = 0
  - S = 0, BUSY = 0, X_READY = Y_READY = 0
  - Reset mid-burst discards the word in O.
- Arbitration latency: VALID rising in IDLE gives READY high on the next cycle (with load_en true).
- Data latency: a word accepted at edge n appears on O with O_VALID after edge n.
- Throughput: one word per cycle while granted and O_READY stays high.
- Burst-limit handover: zero bubble. Y_READY can be high the cycle after X's MAX_BURST-th transfer.
- Handover on VALID drop: one bubble cycle.
- Backpressure: with O_VALID high and O_READY low, O and O_VALID hold, READY is low, and count does not change.
- Simultaneous O_READY and a new transfer on the same edge: O is replaced and O_VALID stays high.

## Test plan
- Reset: hold RST_N=0 for 2 edges with X_VALID=Y_VALID=1 -> O=0, O_VALID=0, S=0, X_READY=Y_READY=0, BUSY=0.
- Single requester: X=2'b01, X_VALID=1, O_READY=1 -> X_READY high 1 cycle later; O=1 with O_VALID one cycle after that; S=0 throughout.
- Tie and burst limit: MAX_BURST=4, X=3 and Y=2 held valid, O_READY=1 -> exactly 4 values of 3, then 4 values of 2, alternating; S toggles with no bubble cycle.
- Burst limit with no contention: only X_VALID, 10 words -> 10 consecutive transfers, state stays GRANT_X, S=0.
- Backpressure: O_READY=0 for 3 cycles with O_VALID=1 -> O stable, X_READY=0, count frozen; O_READY=1 resumes transfers with no word lost or duplicated.
- Withdraw and reset mid-burst:
  - In GRANT_Y, drop Y_VALID with X_VALID=1 -> GRANT_X after one bubble cycle.
  - Pulse RST_N low mid-burst -> all outputs return to reset values on that edge.
